clint_multi: RTL and testbench

CLINT_MULTI -- requirements
Module: clint_multi

---
 rtl/clint_multi.sv | 121 ++++++++++++
 tb/tb_clint_multi.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/clint_multi.sv
// Core-local interruptor for NHART harts: shared 64-bit mtime with a prescaler,
// per-hart mtimecmp/msip, and a single-outstanding valid/ready register port.
module clint_multi #(
  parameter int NHART = 2,
  parameter int XLEN = 64,
  parameter int TICK_DIV = 4096,
  parameter logic [XLEN-1:0] BASE = XLEN'('h2000000)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [XLEN/8-1:0] req_wstrb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err,
  output logic [NHART-1:0]  msip,
  output logic [NHART-1:0]  mtip,
  output logic [63:0]       mtime
);

  localparam int NB = XLEN / 8;
  localparam logic [XLEN-1:0] MTCMP_OFF = XLEN'('h4000);
  localparam logic [XLEN-1:0] MTIME_OFF = XLEN'('hBFF8);

  // Handshake: a request transfers when req_valid && req_ready; a response
  // transfers when rsp_valid && rsp_ready. Only one response is ever held.
  assign req_ready = !rsp_valid || rsp_ready;

  logic [63:0]      mtimecmp [NHART];
  logic [31:0]      presc;
  logic [XLEN-1:0]  off;
  logic             hi, aligned, sel_msip, sel_cmp, sel_time, hit, accept, wr;
  logic [2:0]       msip_idx, cmp_idx;
  logic [XLEN-1:0]  rd_n;
  logic [NHART-1:0] cmp_wr, msip_wr;

  // Byte-lane merge into a 64-bit register; on a 32-bit bus h picks the upper word.
  function automatic logic [63:0] merge(input logic [63:0] old, input logic h,
                                        input logic [XLEN-1:0] d, input logic [NB-1:0] s);
    logic [63:0] r;
    r = old;
    for (int b = 0; b < NB; b++)
      if (s[b]) r[(h ? 32 : 0) + 8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [XLEN-1:0] rd_sel(input logic [63:0] v, input logic h);
    return XLEN'(h ? {32'b0, v[63:32]} : v);
  endfunction

  always_comb begin
    off      = req_addr - BASE;
    hi       = (XLEN == 32) && off[2];
    aligned  = (off[1:0] == 2'b00) && ((XLEN == 32) || !off[2]);
    msip_idx = off[4:2];
    cmp_idx  = off[5:3];
    sel_msip = (off[XLEN-1:5] == '0) && (off[1:0] == 2'b00) && (32'(msip_idx) < NHART);
    sel_cmp  = (off[XLEN-1:6] == MTCMP_OFF[XLEN-1:6]) && aligned && (32'(cmp_idx) < NHART);
    sel_time = (off[XLEN-1:3] == MTIME_OFF[XLEN-1:3]) && aligned;
    hit      = sel_msip || sel_cmp || sel_time;
    accept   = req_valid && req_ready;
    wr       = accept && req_we && hit && (|req_wstrb);
    rd_n     = '0;
    cmp_wr   = '0;
    msip_wr  = '0;
    for (int h = 0; h < NHART; h++) begin
      if (sel_msip && msip_idx == 3'(h)) begin
        rd_n       = XLEN'(msip[h]);
        msip_wr[h] = wr && req_wstrb[0];
      end
      if (sel_cmp && cmp_idx == 3'(h)) begin
        rd_n      = rd_sel(mtimecmp[h], hi);
        cmp_wr[h] = wr;
      end
    end
    if (sel_time) rd_n = rd_sel(mtime, hi);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mtime     <= '0;
      presc     <= '0;
      msip      <= '0;
      mtip      <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      for (int h = 0; h < NHART; h++) mtimecmp[h] <= '1;
    end else begin
      // A software write to mtime wins over the tick and restarts the prescaler.
      if (wr && sel_time) begin
        mtime <= merge(mtime, hi, req_wdata, req_wstrb);
        presc <= '0;
      end else if (presc == 32'(TICK_DIV - 1)) begin
        mtime <= mtime + 64'd1;
        presc <= '0;
      end else begin
        presc <= presc + 32'd1;
      end
      for (int h = 0; h < NHART; h++) begin
        if (cmp_wr[h]) mtimecmp[h] <= merge(mtimecmp[h], hi, req_wdata, req_wstrb);
        if (msip_wr[h]) msip[h] <= req_wdata[0];
        // Mask one cycle after a compare write so a stale match cannot glitch out.
        mtip[h] <= cmp_wr[h] ? 1'b0 : (mtime >= mtimecmp[h]);
      end
      if (accept) begin
        rsp_valid <= 1'b1;
        rsp_err   <= !hit;
        rsp_rdata <= req_we ? '0 : rd_n;
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_clint_multi.sv
// Directed bench: two instances share one bus, one ticking every cycle and one
// every fourth cycle; outputs of each are checked against hand-computed values.
module tb_clint_multi;

  localparam logic [63:0] BASE = 64'h2000000;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we, rsp_ready;
  logic [63:0] req_addr, req_wdata;
  logic [7:0]  req_wstrb;

  logic        req_ready, rsp_valid, rsp_err;
  logic [63:0] rsp_rdata, mtime;
  logic [1:0]  msip, mtip;

  logic        req_ready4, rsp_valid4, rsp_err4;
  logic [63:0] rsp_rdata4, mtime4;
  logic [1:0]  msip4, mtip4;

  int vectors = 0;
  int errs = 0;

  logic [63:0] rd;
  logic        er;
  logic [1:0]  snap_msip, snap_mtip;
  logic [63:0] snap_mtime;

  always #5 clk = ~clk;

  clint_multi #(.NHART(2), .XLEN(64), .TICK_DIV(1), .BASE(BASE)) u1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .msip(msip), .mtip(mtip), .mtime(mtime)
  );

  clint_multi #(.NHART(2), .XLEN(64), .TICK_DIV(4), .BASE(BASE)) u4 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready4),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata4), .rsp_err(rsp_err4),
    .msip(msip4), .mtip(mtip4), .mtime(mtime4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One transfer: accept on the next edge, snapshot state, consume on the following edge.
  task automatic bus(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                     input logic [7:0] strb);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_wstrb = strb;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("bus_rsp_valid", 64'(rsp_valid), 64'd1);
    rd = rsp_rdata; er = rsp_err;
    snap_msip = msip; snap_mtip = mtip; snap_mtime = mtime;
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_wstrb = '0; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mtime", mtime, 64'd0);
    chk("rst_msip", 64'(msip), 64'd0);
    chk("rst_mtip", 64'(mtip), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rdata", rsp_rdata, 64'd0);
    rst = 1'b0;
    chk("ready_after_rst", 64'(req_ready), 64'd1);

    repeat (40) @(posedge clk);
    #1;
    chk("idle40_mtime_div4", mtime4, 64'd10);
    chk("idle40_mtip_div4", 64'(mtip4), 64'd0);
    chk("idle40_mtime_div1", mtime, 64'd40);

    // Unmapped read with response backpressure.
    req_valid = 1'b1; req_we = 1'b0; req_addr = BASE + 64'h8000; req_wstrb = '0;
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("unmapped_valid", 64'(rsp_valid), 64'd1);
      chk("unmapped_err", 64'(rsp_err), 64'd1);
      chk("unmapped_rdata", rsp_rdata, 64'd0);
      chk("stall_req_ready", 64'(req_ready), 64'd0);
      if (i < 3) begin @(posedge clk); #1; end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("unmapped_consumed", 64'(rsp_valid), 64'd0);

    // Single-byte write into mtimecmp[0].
    bus(1'b1, BASE + 64'h4000, 64'h12, 8'h01);
    chk("cmp0_byte_wr_err", 64'(er), 64'd0);
    chk("cmp0_byte_wr_rdata", rd, 64'd0);
    bus(1'b0, BASE + 64'h4000, 64'd0, 8'h00);
    chk("cmp0_byte_rd", rd, 64'hFFFF_FFFF_FFFF_FF12);

    // MSIP set then clear.
    chk("msip_before", 64'(msip), 64'd0);
    bus(1'b1, BASE, 64'd1, 8'hFF);
    chk("msip_set_next_cycle", 64'(snap_msip), 64'd1);
    chk("msip_set", 64'(msip), 64'd1);
    bus(1'b0, BASE, 64'd0, 8'h00);
    chk("msip_rd1", rd, 64'd1);
    bus(1'b1, BASE, 64'd0, 8'hFF);
    chk("msip_clr", 64'(msip), 64'd0);
    bus(1'b0, BASE, 64'd0, 8'h00);
    chk("msip_rd0", rd, 64'd0);

    // Zero-strobe write and out-of-range hart accesses.
    bus(1'b1, BASE, 64'd1, 8'h00);
    chk("wstrb0_err", 64'(er), 64'd0);
    chk("wstrb0_msip", 64'(msip), 64'd0);
    bus(1'b1, BASE + 64'h8, 64'd1, 8'hFF);
    chk("msip2_err", 64'(er), 64'd1);
    chk("msip2_rdata", rd, 64'd0);
    chk("msip2_no_effect", 64'(msip), 64'd0);
    bus(1'b0, BASE + 64'h4010, 64'd0, 8'h00);
    chk("cmp2_rd_err", 64'(er), 64'd1);
    chk("cmp2_rd_rdata", rd, 64'd0);

    // Timer compare on hart 1.
    bus(1'b1, BASE + 64'hBFF8, 64'd0, 8'hFF);
    chk("mtime_wr0", mtime, 64'd1);
    bus(1'b1, BASE + 64'h4008, 64'd5, 8'hFF);
    chk("cmp1_wr_mtip_next", 64'(snap_mtip), 64'd0);
    chk("cmp1_mtip_after", 64'(mtip), 64'd0);
    n = 0;
    while (!mtip[1] && n < 20) begin @(posedge clk); #1; n++; end
    chk("mtip1_rise_cycles", 64'(n), 64'd3);
    chk("mtip1_rise_mtime", mtime, 64'd6);
    chk("mtip0_stays", 64'(mtip[0]), 64'd0);
    bus(1'b1, BASE + 64'h4008, 64'd5, 8'hFF);
    chk("cmp1_mask", 64'(snap_mtip), 64'd0);
    chk("cmp1_reeval", 64'(mtip), 64'd2);

    // mtime wraparound.
    bus(1'b1, BASE + 64'hBFF8, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF);
    chk("mtime_pre_wrap", mtime, 64'hFFFF_FFFF_FFFF_FFFF);
    bus(1'b0, BASE + 64'hBFF8, 64'd0, 8'h00);
    chk("mtime_rd_pre_edge", rd, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("mtime_wrapped", snap_mtime, 64'd0);
    chk("mtime_after_wrap", mtime, 64'd1);

    // Reset during an outstanding response with a concurrent write.
    req_valid = 1'b1; req_we = 1'b0; req_addr = BASE; req_wstrb = '0; rsp_ready = 1'b0;
    @(posedge clk); #1;
    chk("pend_valid", 64'(rsp_valid), 64'd1);
    rst = 1'b1; req_we = 1'b1; req_wdata = 64'd1; req_wstrb = 8'hFF;
    @(posedge clk); #1;
    chk("rst_drop_valid", 64'(rsp_valid), 64'd0);
    chk("rst_drop_msip", 64'(msip), 64'd0);
    chk("rst_drop_mtime", mtime, 64'd0);
    rst = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
    chk("rst2_ready", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    chk("rst2_msip", 64'(msip), 64'd0);
    bus(1'b0, BASE + 64'h4008, 64'd0, 8'h00);
    chk("rst2_cmp1", rd, 64'hFFFF_FFFF_FFFF_FFFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
